// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, one bit per clock, LSB first.
// A full-adder bit is built from two half_adder cells and an OR gate; the
// carry lives in a single flop between bit slots.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   start      add request, honoured only in IDLE or DONE
//   op_a/op_b  WIDTH-bit operands, captured when start is accepted
//   busy       high while bits are being shifted through the adder
//   done       one-cycle strobe, result/carry_out valid
//   result     (op_a + op_b) mod 2^WIDTH, held until the next completion
//   carry_out  carry out of bit WIDTH-1, held with result

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit pair added per clock
// DONE  | done strobe cycle; start here begins the next add immediately
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   // Down-counter of remaining bit slots; terminal count 0 marks the last bit.
   logic [CW-1:0]    cnt;

   logic             p0;
   logic             g0;
   logic             s_bit;
   logic             g1;
   logic             c_next;
   logic [WIDTH-1:0] sum_next;

   half_adder u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(p0),    .c(g0));
   half_adder u_ha1 (.a(p0),      .b(carry),   .s(s_bit), .c(g1));
   assign c_next = g0 | g1;

   // Right shift with the new sum bit entering at the MSB; written this way
   // so it stays legal when WIDTH is 1.
   always_comb begin
      sum_next = sum_sr >> 1;
      sum_next[WIDTH-1] = s_bit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= op_a;
                  b_sr   <= op_b;
                  sum_sr <= '0;
                  carry  <= 1'b0;
                  cnt    <= CW'(WIDTH - 1);
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_next;
               carry  <= c_next;
               if (cnt == '0) begin
                  result    <= sum_next;
                  carry_out <= c_next;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
